// File: rtl/load_data_formatter_if.sv
// Load-data formatter handshake bundle: producer-side entry fields, consumer-side
// head entry, and the error-counter controls.
interface load_data_formatter_if #(
    parameter int NB_DATA   = 32,
    parameter int NB_MASK   = 2,
    parameter int NB_OFFSET = 3,
    parameter int NB_ERRCNT = 8
);
    logic                 i_valid;
    logic                 o_ready;
    logic [NB_DATA-1:0]   i_dato;
    logic [NB_OFFSET-1:0] i_offset;
    logic [NB_MASK-1:0]   i_mascara;
    logic                 i_is_unsigned;
    logic                 o_valid;
    logic                 i_ready;
    logic [NB_DATA-1:0]   o_dato;
    logic                 o_err;
    logic                 i_err_clear;
    logic [NB_ERRCNT-1:0] o_err_count;

    // The formatter itself.
    modport slave (
        input  i_valid, i_dato, i_offset, i_mascara, i_is_unsigned, i_ready, i_err_clear,
        output o_ready, o_valid, o_dato, o_err, o_err_count
    );

    // The MEM-stage producer and WB-stage consumer.
    modport master (
        output i_valid, i_dato, i_offset, i_mascara, i_is_unsigned, i_ready, i_err_clear,
        input  o_ready, o_valid, o_dato, o_err, o_err_count
    );
endinterface

// File: rtl/load_data_formatter.sv
// MEM/WB load-data formatter: lane select plus sign/zero extension, alignment
// checking, a saturating error counter, and a 2-entry skid queue.
module load_data_formatter #(
    parameter int NB_DATA   = 32,
    parameter int NB_MASK   = 2,
    parameter int NB_OFFSET = 3,
    parameter int NB_ERRCNT = 8
) (
    input logic                    i_clock,
    input logic                    i_reset,
    load_data_formatter_if.slave   bus
);
    localparam int OFF_W = $clog2(NB_DATA / 8);
    localparam int SH_W  = OFF_W + 3;
    localparam logic [SH_W-1:0] LOW4 = SH_W'(15);
    localparam logic [SH_W-1:0] LOW5 = SH_W'(31);

    logic [OFF_W-1:0]   off;
    logic [SH_W-1:0]    sh_b;
    logic [SH_W-1:0]    sh_h;
    logic [SH_W-1:0]    sh_w;
    logic [7:0]         f8;
    logic [15:0]        f16;
    logic [31:0]        f32;
    logic [NB_DATA-1:0] fmt_dat;
    logic               fmt_err;
    logic               unused_offset_hi;

    assign off              = bus.i_offset[OFF_W-1:0];
    assign unused_offset_hi = ^bus.i_offset;

    // Bit shifts are the byte offset rounded down to the access alignment.
    assign sh_b = {off, 3'b000};
    assign sh_h = sh_b & ~LOW4;
    assign sh_w = sh_b & ~LOW5;
    assign f8   = 8'(bus.i_dato >> sh_b);
    assign f16  = 16'(bus.i_dato >> sh_h);
    assign f32  = 32'(bus.i_dato >> sh_w);

    always_comb begin
        fmt_dat = '0;
        fmt_err = 1'b0;
        case (bus.i_mascara)
            2'b00: begin
                if (bus.i_is_unsigned) fmt_dat = NB_DATA'(f8);
                else                   fmt_dat = NB_DATA'($signed(f8));
            end
            2'b01: begin
                if (off[0])                 fmt_err = 1'b1;
                else if (bus.i_is_unsigned) fmt_dat = NB_DATA'(f16);
                else                        fmt_dat = NB_DATA'($signed(f16));
            end
            2'b10: begin
                if (off[1:0] != 2'b00)      fmt_err = 1'b1;
                else if (bus.i_is_unsigned) fmt_dat = NB_DATA'(f32);
                else                        fmt_dat = NB_DATA'($signed(f32));
            end
            default: begin
                if (NB_DATA == 32 || off != '0) fmt_err = 1'b1;
                else                            fmt_dat = bus.i_dato;
            end
        endcase
    end

    logic [NB_DATA-1:0]   dat_q [2];
    logic                 err_q [2];
    logic [1:0]           count;
    logic [NB_ERRCNT-1:0] err_cnt;
    logic                 push;
    logic                 pop;

    assign bus.o_ready     = (count < 2'd2) && !i_reset;
    assign bus.o_valid     = (count != 2'd0);
    assign bus.o_dato      = dat_q[0];
    assign bus.o_err       = err_q[0];
    assign bus.o_err_count = err_cnt;
    assign push            = bus.i_valid && bus.o_ready;
    assign pop             = bus.o_valid && bus.i_ready;

    // Slot 0 is always the head; empty slots are kept zero so the head reads 0 when empty.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count    <= '0;
            dat_q[0] <= '0;
            dat_q[1] <= '0;
            err_q[0] <= 1'b0;
            err_q[1] <= 1'b0;
            err_cnt  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        dat_q[0] <= fmt_dat;
                        err_q[0] <= fmt_err;
                    end else begin
                        dat_q[1] <= fmt_dat;
                        err_q[1] <= fmt_err;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    dat_q[0] <= dat_q[1];
                    err_q[0] <= err_q[1];
                    dat_q[1] <= '0;
                    err_q[1] <= 1'b0;
                    count    <= count - 2'd1;
                end
                // Push with pop only happens at count 1 (full blocks push, empty blocks pop).
                2'b11: begin
                    dat_q[0] <= fmt_dat;
                    err_q[0] <= fmt_err;
                end
                default: ;
            endcase

            if (bus.i_err_clear)
                err_cnt <= (push && fmt_err) ? NB_ERRCNT'(1) : '0;
            else if (push && fmt_err && err_cnt != '1)
                err_cnt <= err_cnt + NB_ERRCNT'(1);
        end
    end
endmodule

// File: tb/tb_load_data_formatter.sv
// Directed-vector bench for load_data_formatter: a 32-bit instance with a 2-bit
// error counter and a 64-bit instance with the default counter.
module tb_load_data_formatter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    load_data_formatter_if #(.NB_DATA(32), .NB_ERRCNT(2)) a_if ();
    load_data_formatter_if #(.NB_DATA(64)) b_if ();

    load_data_formatter #(.NB_DATA(32), .NB_ERRCNT(2)) dut32 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (a_if.slave)
    );

    load_data_formatter #(.NB_DATA(64)) dut64 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (b_if.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are checked 1 ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] d, input logic [2:0] o, input logic [1:0] m,
                          input logic u);
        a_if.i_valid = 1'b1; a_if.i_dato = d; a_if.i_offset = o;
        a_if.i_mascara = m;  a_if.i_is_unsigned = u;
        step();
        a_if.i_valid = 1'b0;
    endtask

    task automatic push_b(input logic [63:0] d, input logic [2:0] o, input logic [1:0] m,
                          input logic u);
        b_if.i_valid = 1'b1; b_if.i_dato = d; b_if.i_offset = o;
        b_if.i_mascara = m;  b_if.i_is_unsigned = u;
        step();
        b_if.i_valid = 1'b0;
    endtask

    initial begin
        a_if.i_valid = 1'b0; a_if.i_dato = '0; a_if.i_offset = '0; a_if.i_mascara = '0;
        a_if.i_is_unsigned = 1'b0; a_if.i_ready = 1'b1; a_if.i_err_clear = 1'b0;
        b_if.i_valid = 1'b0; b_if.i_dato = '0; b_if.i_offset = '0; b_if.i_mascara = '0;
        b_if.i_is_unsigned = 1'b0; b_if.i_ready = 1'b1; b_if.i_err_clear = 1'b0;

        step(); step();
        check("rst_valid", 64'(a_if.o_valid), 64'd0);
        check("rst_dato", 64'(a_if.o_dato), 64'd0);
        check("rst_errcnt", 64'(a_if.o_err_count), 64'd0);
        check("rst_ready", 64'(a_if.o_ready), 64'd0);
        rst = 1'b0;
        step();
        check("post_rst_ready", 64'(a_if.o_ready), 64'd1);

        // 32-bit formatting, one cycle latency, consumer always ready
        push_a(32'h8000_0000, 3'd3, 2'b00, 1'b0);
        check("lat_valid", 64'(a_if.o_valid), 64'd1);
        check("b3_signed", 64'(a_if.o_dato), 64'hFFFF_FF80);
        check("b3_signed_err", 64'(a_if.o_err), 64'd0);
        push_a(32'h8000_0000, 3'd3, 2'b00, 1'b1);
        check("b3_unsigned", 64'(a_if.o_dato), 64'h0000_0080);
        push_a(32'h8001_7FFF, 3'd2, 2'b01, 1'b0);
        check("h2_signed", 64'(a_if.o_dato), 64'hFFFF_8001);
        push_a(32'h8001_7FFF, 3'd0, 2'b01, 1'b0);
        check("h0_signed", 64'(a_if.o_dato), 64'h0000_7FFF);
        push_a(32'h8001_7FFF, 3'd1, 2'b01, 1'b0);
        check("h1_err", 64'(a_if.o_err), 64'd1);
        check("h1_dato", 64'(a_if.o_dato), 64'd0);
        check("h1_errcnt", 64'(a_if.o_err_count), 64'd1);
        push_a(32'h4433_2211, 3'd5, 2'b00, 1'b1);
        check("b5_hi_ignored", 64'(a_if.o_dato), 64'h0000_0022);
        push_a(32'h1234_5678, 3'd0, 2'b11, 1'b0);
        check("d32_illegal_err", 64'(a_if.o_err), 64'd1);
        check("d32_illegal_dato", 64'(a_if.o_dato), 64'd0);
        push_a(32'h8000_0000, 3'd0, 2'b10, 1'b0);
        check("w0_pass", 64'(a_if.o_dato), 64'h8000_0000);
        check("w0_err", 64'(a_if.o_err), 64'd0);
        step();
        check("drained", 64'(a_if.o_valid), 64'd0);

        // error counter with 2-bit saturation
        a_if.i_err_clear = 1'b1;
        step();
        a_if.i_err_clear = 1'b0;
        check("clr_alone0", 64'(a_if.o_err_count), 64'd0);
        push_a(32'h0, 3'd1, 2'b10, 1'b0); check("sat1", 64'(a_if.o_err_count), 64'd1);
        push_a(32'h0, 3'd2, 2'b10, 1'b0); check("sat2", 64'(a_if.o_err_count), 64'd2);
        push_a(32'h0, 3'd3, 2'b01, 1'b0); check("sat3", 64'(a_if.o_err_count), 64'd3);
        push_a(32'h0, 3'd0, 2'b11, 1'b0); check("sat4", 64'(a_if.o_err_count), 64'd3);
        push_a(32'h0, 3'd1, 2'b01, 1'b1); check("sat5", 64'(a_if.o_err_count), 64'd3);
        a_if.i_err_clear = 1'b1;
        push_a(32'h0, 3'd1, 2'b01, 1'b0);
        check("clr_with_err", 64'(a_if.o_err_count), 64'd1);
        step();
        a_if.i_err_clear = 1'b0;
        check("clr_alone", 64'(a_if.o_err_count), 64'd0);
        check("empty_before_bp", 64'(a_if.o_valid), 64'd0);

        // back-pressure: third word held off until the queue drains
        a_if.i_ready = 1'b0;
        a_if.i_valid = 1'b1; a_if.i_mascara = 2'b10; a_if.i_offset = 3'd0;
        a_if.i_is_unsigned = 1'b1;
        a_if.i_dato = 32'h11; step();
        check("bp_ready_c1", 64'(a_if.o_ready), 64'd1);
        a_if.i_dato = 32'h22; step();
        check("bp_ready_c2", 64'(a_if.o_ready), 64'd0);
        check("bp_head_c2", 64'(a_if.o_dato), 64'h11);
        a_if.i_dato = 32'h33; step();
        check("bp_ready_held", 64'(a_if.o_ready), 64'd0);
        check("bp_head_held", 64'(a_if.o_dato), 64'h11);
        step();
        check("bp_valid_held", 64'(a_if.o_valid), 64'd1);
        check("bp_head_held2", 64'(a_if.o_dato), 64'h11);
        a_if.i_ready = 1'b1;
        step();
        check("bp_head_22", 64'(a_if.o_dato), 64'h22);
        check("bp_ready_back", 64'(a_if.o_ready), 64'd1);
        step();
        check("bp_head_33", 64'(a_if.o_dato), 64'h33);
        check("pushpop_valid", 64'(a_if.o_valid), 64'd1);
        check("pushpop_ready", 64'(a_if.o_ready), 64'd1);
        a_if.i_valid = 1'b0;
        step();
        check("bp_empty_valid", 64'(a_if.o_valid), 64'd0);
        check("bp_empty_dato", 64'(a_if.o_dato), 64'd0);

        // reset mid-operation with a full queue and a nonzero error count
        a_if.i_ready = 1'b0;
        push_a(32'h0, 3'd1, 2'b01, 1'b0);
        push_a(32'hBB, 3'd0, 2'b10, 1'b0);
        check("mr_full", 64'(a_if.o_ready), 64'd0);
        check("mr_errcnt_pre", 64'(a_if.o_err_count), 64'd1);
        rst = 1'b1;
        a_if.i_valid = 1'b1; a_if.i_dato = 32'hCC;
        step();
        check("mr_valid", 64'(a_if.o_valid), 64'd0);
        check("mr_dato", 64'(a_if.o_dato), 64'd0);
        check("mr_err", 64'(a_if.o_err), 64'd0);
        check("mr_errcnt", 64'(a_if.o_err_count), 64'd0);
        check("mr_ready", 64'(a_if.o_ready), 64'd0);
        rst = 1'b0;
        a_if.i_valid = 1'b0; a_if.i_ready = 1'b1;
        step();
        check("mr_ready_after", 64'(a_if.o_ready), 64'd1);
        check("mr_no_stale", 64'(a_if.o_valid), 64'd0);
        step();
        check("mr_no_stale2", 64'(a_if.o_valid), 64'd0);

        // 64-bit instance
        push_b(64'h0123_4567_89AB_CDEF, 3'd0, 2'b11, 1'b0);
        check("d64_pass", b_if.o_dato, 64'h0123_4567_89AB_CDEF);
        check("d64_pass_err", 64'(b_if.o_err), 64'd0);
        push_b(64'h8000_0000_1234_5678, 3'd4, 2'b10, 1'b0);
        check("w4_signed", b_if.o_dato, 64'hFFFF_FFFF_8000_0000);
        push_b(64'h8000_0000_1234_5678, 3'd0, 2'b10, 1'b1);
        check("w0_64", b_if.o_dato, 64'h0000_0000_1234_5678);
        push_b(64'h0123_4567_89AB_CDEF, 3'd4, 2'b11, 1'b0);
        check("d4_err", 64'(b_if.o_err), 64'd1);
        check("d4_dato", b_if.o_dato, 64'd0);
        check("d4_errcnt", 64'(b_if.o_err_count), 64'd1);
        push_b(64'hFE00_0000_0000_0000, 3'd7, 2'b00, 1'b0);
        check("b7_signed64", b_if.o_dato, 64'hFFFF_FFFF_FFFF_FFFE);
        push_b(64'h8001_0000_0000_0000, 3'd6, 2'b01, 1'b1);
        check("h6_unsigned64", b_if.o_dato, 64'h0000_0000_0000_8001);
        step();
        check("b_drained", 64'(b_if.o_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
